mul_hilo_ctrl: RTL and testbench

MUL_HILO_CTRL -- requirements
Module: mul_hilo_ctrl

---
 rtl/mul_pkg.sv | 17 +
 rtl/hilo_regs.sv | 28 ++
 rtl/mul_hilo_ctrl.sv | 129 ++++++++++++
 tb/tb_mul_hilo_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the HI/LO multiply controller.
//   mul_state_e     - controller state encoding (exposed on the debug port)
//   SETTLE_MIN/MAX  - legal bounds of the SETTLE_CYCLES parameter
//   CNT_W           - width of the settle counter
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2
  } mul_state_e;

  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/hilo_regs.sv
// hilo_regs: the architectural HI/LO register pair.
// Ports:
//   clock, clear   - rising-edge clock, asynchronous active-high clear
//   hi_ld, lo_ld   - load enables
//   hi_d, lo_d     - data loaded when the matching enable is high
//   hi_q, lo_q     - current register contents
module hilo_regs (
  input  logic        clock,
  input  logic        clear,
  input  logic        hi_ld,
  input  logic        lo_ld,
  input  logic [31:0] hi_d,
  input  logic [31:0] lo_d,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_ld) hi_q <= hi_d;
      if (lo_ld) lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl: sequences an external combinational 32x32 signed multiplier
// and owns the HI/LO registers.
// Ports:
//   clock, clear           - clock, asynchronous active-high reset
//   start, op_a, op_b      - multiply request and operands
//   mul_x, mul_y, mul_en   - registered operands / in-flight flag to the multiplier
//   mul_z_high, mul_z_low  - product returned by the multiplier
//   mthi_en, mtlo_en,
//   wr_data                - direct HI/LO writes (accepted only when idle)
//   hi_out, lo_out         - current HI/LO
//   busy                   - operation in flight
//   done                   - one-cycle pulse after HI/LO capture
//   wr_reject              - one-cycle pulse after a dropped mthi/mtlo
//   state_dbg              - current controller state
// Handshake: start is a level request sampled only in IDLE; there is no
// queuing, so a requester must hold start (or retry) until busy is seen.
module mul_hilo_ctrl
  import mul_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  output logic        mul_en,
  input  logic [31:0] mul_z_low,
  input  logic [31:0] mul_z_high,
  input  logic        mthi_en,
  input  logic        mtlo_en,
  input  logic [31:0] wr_data,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        wr_reject,
  output mul_state_e  state_dbg
);

  // Counter is loaded with SETTLE_CYCLES-1 and SETTLE exits on zero, which
  // gives exactly SETTLE_CYCLES cycles of settling before CAPTURE.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  mul_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              ld_ops;
  logic              hi_ld, lo_ld;
  logic [31:0]       hi_d, lo_d;
  logic              done_nxt, rej_nxt;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mul_x     <= '0;
      mul_y     <= '0;
      done      <= 1'b0;
      wr_reject <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      done      <= done_nxt;
      wr_reject <= rej_nxt;
      if (ld_ops) begin
        mul_x <= op_a;
        mul_y <= op_b;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ld_ops    = 1'b0;
    hi_ld     = 1'b0;
    lo_ld     = 1'b0;
    hi_d      = wr_data;
    lo_d      = wr_data;
    done_nxt  = 1'b0;
    rej_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        // Direct writes and a new start may coincide; the capture comes
        // later and overwrites whatever was written here.
        hi_ld = mthi_en;
        lo_ld = mtlo_en;
        if (start) begin
          ld_ops    = 1'b1;
          cnt_nxt   = CNT_LOAD;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        rej_nxt = mthi_en | mtlo_en;
        if (cnt == '0) state_nxt = ST_CAPTURE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      ST_CAPTURE: begin
        rej_nxt   = mthi_en | mtlo_en;
        hi_ld     = 1'b1;
        lo_ld     = 1'b1;
        hi_d      = mul_z_high;
        lo_d      = mul_z_low;
        done_nxt  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign mul_en    = busy;
  assign state_dbg = state;

  hilo_regs u_hilo (
    .clock (clock),
    .clear (clear),
    .hi_ld (hi_ld),
    .lo_ld (lo_ld),
    .hi_d  (hi_d),
    .lo_d  (lo_d),
    .hi_q  (hi_out),
    .lo_q  (lo_out)
  );

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Bench for mul_hilo_ctrl with a behavioural signed multiplier and a
// timeline-based reference model of HI/LO, busy and the pulses.
module tb_mul_hilo_ctrl;
  import mul_pkg::*;

  localparam int S = 2;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op_a = '0, op_b = '0, wr_data = '0;
  logic        mthi_en = 1'b0, mtlo_en = 1'b0;
  logic [31:0] mul_x, mul_y, mul_z_low, mul_z_high, hi_out, lo_out;
  logic        mul_en, busy, done, wr_reject;
  mul_state_e  state_dbg;
  logic [63:0] prod;

  int total = 0;
  int bad   = 0;

  // reference model: m_rem = edges left until capture (0 = idle)
  int          m_rem = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_x = '0, m_y = '0;
  logic [63:0] m_pend = '0;
  logic        m_done = 1'b0, m_rej = 1'b0;

  always #5 clock = ~clock;

  // behavioural signed 32x32 multiplier
  always_comb prod = 64'(longint'($signed(mul_x)) * longint'($signed(mul_y)));
  assign mul_z_high = prod[63:32];
  assign mul_z_low  = prod[31:0];

  mul_hilo_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clock(clock), .clear(clear), .start(start), .op_a(op_a), .op_b(op_b),
    .mul_x(mul_x), .mul_y(mul_y), .mul_en(mul_en),
    .mul_z_low(mul_z_low), .mul_z_high(mul_z_high),
    .mthi_en(mthi_en), .mtlo_en(mtlo_en), .wr_data(wr_data),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done),
    .wr_reject(wr_reject), .state_dbg(state_dbg)
  );

  task automatic model_reset();
    m_rem = 0; m_hi = '0; m_lo = '0; m_x = '0; m_y = '0;
    m_done = 1'b0; m_rej = 1'b0;
  endtask

  // apply one rising edge to the model using the currently driven inputs
  task automatic model_edge();
    if (clear) begin
      model_reset();
    end else begin
      m_done = 1'b0;
      m_rej  = 1'b0;
      if (m_rem > 0) begin
        m_rej = mthi_en | mtlo_en;
        m_rem--;
        if (m_rem == 0) begin
          m_hi = m_pend[63:32];
          m_lo = m_pend[31:0];
          m_done = 1'b1;
        end
      end else begin
        if (mthi_en) m_hi = wr_data;
        if (mtlo_en) m_lo = wr_data;
        if (start) begin
          m_x = op_a;
          m_y = op_b;
          m_pend = 64'(longint'($signed(op_a)) * longint'($signed(op_b)));
          m_rem = S + 1;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    #1;
    total++;
    if ({hi_out, lo_out, mul_x, mul_y, busy, mul_en, done, wr_reject} !== '0) begin
      bad++;
      $display("FAIL reset_async hi=%h lo=%h x=%h y=%h busy=%b en=%b done=%b rej=%b required all 0",
               hi_out, lo_out, mul_x, mul_y, busy, mul_en, done, wr_reject);
    end
    start = 1'b1; mthi_en = 1'b1; wr_data = 32'hFFFF_FFFF;
    tick(); tick();
    total++;
    if ({hi_out, lo_out, mul_x, mul_y, busy, mul_en, done, wr_reject} !== '0) begin
      bad++;
      $display("FAIL reset_held hi=%h lo=%h busy=%b required 0", hi_out, lo_out, busy);
    end
    start = 1'b0; mthi_en = 1'b0;
    clear = 1'b0;
  endtask

  task automatic test_product(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                              input string nm);
    logic [31:0] hi0, lo0;
    int dn;
    hi0 = m_hi; lo0 = m_lo; dn = 0;
    op_a = a; op_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || mul_en !== 1'b1 || mul_x !== a || mul_y !== b) begin
      bad++;
      $display("FAIL %s_accept busy=%b en=%b x=%h y=%h required 1 1 %h %h", nm, busy, mul_en, mul_x, mul_y, a, b);
    end
    for (int i = 0; i < S; i++) begin
      tick();
      total++;
      if (hi_out !== hi0 || lo_out !== lo0 || done !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL %s_settle%0d hi=%h lo=%h done=%b busy=%b required %h %h 0 1", nm, i, hi_out, lo_out, done, busy, hi0, lo0);
      end
    end
    tick();
    if (done === 1'b1) dn++;
    total++;
    if (hi_out !== exp_hi || lo_out !== exp_lo || done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_capture hi=%h lo=%h done=%b busy=%b required %h %h 1 0", nm, hi_out, lo_out, done, busy, exp_hi, exp_lo);
    end
    tick();
    if (done === 1'b1) dn++;
    total++;
    if (dn !== 1 || hi_out !== exp_hi || lo_out !== exp_lo) begin
      bad++;
      $display("FAIL %s_single_done pulses=%0d hi=%h lo=%h required 1 %h %h", nm, dn, hi_out, lo_out, exp_hi, exp_lo);
    end
  endtask

  task automatic test_mthi_reject();
    logic [31:0] hi0;
    op_a = $urandom; op_b = $urandom; start = 1'b1;
    tick();
    start = 1'b0;
    hi0 = m_hi;
    mthi_en = 1'b1; wr_data = 32'h1234_5678;
    tick();
    mthi_en = 1'b0;
    total++;
    if (wr_reject !== 1'b1 || hi_out !== hi0) begin
      bad++;
      $display("FAIL reject_pulse rej=%b hi=%h required 1 %h", wr_reject, hi_out, hi0);
    end
    tick();
    total++;
    if (wr_reject !== 1'b0) begin
      bad++;
      $display("FAIL reject_one_cycle rej=%b required 0", wr_reject);
    end
    for (int i = 0; i < 10 && m_rem > 0; i++) tick();
    total++;
    if (busy !== 1'b0 || hi_out !== m_hi || lo_out !== m_lo) begin
      bad++;
      $display("FAIL reject_op_result busy=%b hi=%h lo=%h required 0 %h %h", busy, hi_out, lo_out, m_hi, m_lo);
    end
    mthi_en = 1'b1; wr_data = 32'h1234_5678;
    tick();
    mthi_en = 1'b0;
    total++;
    if (hi_out !== 32'h1234_5678 || wr_reject !== 1'b0) begin
      bad++;
      $display("FAIL idle_mthi hi=%h rej=%b required 12345678 0", hi_out, wr_reject);
    end
  endtask

  task automatic test_back_to_back();
    int dn, rises;
    logic busy_q;
    dn = 0; rises = 0; busy_q = busy;
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      op_a = $urandom; op_b = $urandom;
      if (i == 6) start = 1'b0;
      tick();
      if (done === 1'b1) dn++;
      if (busy === 1'b1 && busy_q !== 1'b1) rises++;
      busy_q = busy;
      total++;
      if (busy !== (m_rem > 0) || hi_out !== m_hi || lo_out !== m_lo || done !== m_done) begin
        bad++;
        $display("FAIL b2b_cycle%0d busy=%b hi=%h lo=%h done=%b required %b %h %h %b",
                 i, busy, hi_out, lo_out, done, (m_rem > 0), m_hi, m_lo, m_done);
      end
    end
    // start sampled at 6 edges: accepted at the first and again at IDLE re-entry
    total++;
    if (dn !== 2 || rises !== 2) begin
      bad++;
      $display("FAIL b2b_count done=%0d ops=%0d required 2 2", dn, rises);
    end
  endtask

  task automatic test_clear_mid();
    int dn;
    dn = 0;
    op_a = $urandom; op_b = $urandom; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    clear = 1'b1;
    #1;
    model_reset();
    total++;
    if ({hi_out, lo_out, mul_x, mul_y, busy, mul_en, done, wr_reject} !== '0) begin
      bad++;
      $display("FAIL clear_mid hi=%h lo=%h x=%h busy=%b required all 0", hi_out, lo_out, mul_x, busy);
    end
    tick();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1) dn++;
    end
    total++;
    if (dn !== 0 || hi_out !== 32'h0 || lo_out !== 32'h0) begin
      bad++;
      $display("FAIL clear_no_done pulses=%0d hi=%h lo=%h required 0 0 0", dn, hi_out, lo_out);
    end
    test_product(32'hFFFF_FFF9, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFDD, "after_clear");
  endtask

  task automatic test_first_start_after_clear();
    clear = 1'b1;
    #1;
    model_reset();
    tick();
    clear = 1'b0;
    op_a = 32'd7; op_b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || mul_x !== 32'd7 || mul_y !== 32'd9) begin
      bad++;
      $display("FAIL first_start busy=%b x=%h y=%h required 1 7 9", busy, mul_x, mul_y);
    end
    for (int i = 0; i < S + 1; i++) tick();
    total++;
    if (hi_out !== 32'h0 || lo_out !== 32'd63) begin
      bad++;
      $display("FAIL first_start_result hi=%h lo=%h required 0 3f", hi_out, lo_out);
    end
  endtask

  task automatic test_start_mtlo();
    logic [63:0] p;
    op_a = $urandom; op_b = $urandom;
    p = 64'(longint'($signed(op_a)) * longint'($signed(op_b)));
    start = 1'b1; mtlo_en = 1'b1; wr_data = 32'hAAAA_0000;
    tick();
    start = 1'b0; mtlo_en = 1'b0;
    for (int i = 0; i < S + 1; i++) begin
      total++;
      if (lo_out !== 32'hAAAA_0000) begin
        bad++;
        $display("FAIL mtlo_hold%0d lo=%h required aaaa0000", i, lo_out);
      end
      if (i < S) tick();
    end
    tick();
    total++;
    if (lo_out !== p[31:0] || hi_out !== p[63:32]) begin
      bad++;
      $display("FAIL mtlo_overwrite hi=%h lo=%h required %h %h", hi_out, lo_out, p[63:32], p[31:0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      start   = ($urandom_range(0, 3) == 0);
      mthi_en = ($urandom_range(0, 4) == 0);
      mtlo_en = ($urandom_range(0, 4) == 0);
      wr_data = $urandom;
      op_a    = $urandom;
      op_b    = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
      tick();
      total++;
      if (hi_out !== m_hi || lo_out !== m_lo || mul_x !== m_x || mul_y !== m_y ||
          busy !== (m_rem > 0) || mul_en !== (m_rem > 0) || done !== m_done || wr_reject !== m_rej) begin
        bad++;
        $display("FAIL rand%0d hi=%h lo=%h x=%h y=%h busy=%b done=%b rej=%b required %h %h %h %h %b %b %b",
                 i, hi_out, lo_out, mul_x, mul_y, busy, done, wr_reject,
                 m_hi, m_lo, m_x, m_y, (m_rem > 0), m_done, m_rej);
      end
    end
    start = 1'b0; mthi_en = 1'b0; mtlo_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_product(32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "neg");
    test_product(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, "maxpos");
    test_product(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "maxneg");
    test_mthi_reject();
    test_back_to_back();
    test_clear_mid();
    test_first_start_after_clear();
    test_start_mtlo();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
